// File: rtl/xc_aes_pkg.sv
// Shared definitions for the sequential AES inverse-SubBytes (decrypt) unit:
// FSM states, byte counter width, byte-lane indices and a word rotate helper.
package xc_aes_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LANE0 = 2'd0;
    localparam logic [CNT_W-1:0] LANE1 = 2'd1;
    localparam logic [CNT_W-1:0] LANE2 = 2'd2;
    localparam logic [CNT_W-1:0] LANE3 = 2'd3;

    function automatic logic [31:0] rotl8(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/xc_aes_inv_sbox.sv
// AES inverse S-box as a pure lookup; byte 0 of the table is the leftmost entry.
module xc_aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/xc_aessub_decrot_seq.sv
// Byte-serial AES inverse-SubBytes with optional 8-bit left rotate, using one
// shared inverse S-box; fixed 5-cycle latency from valid to the ready pulse.
module xc_aessub_decrot_seq
    import xc_aes_pkg::*;
#(
    parameter logic ROT_DEFAULT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        rot_sel,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result,
    output logic        busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic             rot_q, rot_d;
    logic [31:0]      work_q, work_d;
    logic [31:0]      result_q, result_d;
    logic [7:0]       sbox_in;
    logic [7:0]       sbox_out;
    logic [31:0]      merged;

    always_comb begin
        sbox_in = rs1_q[7:0];
        case (cnt_q)
            LANE0:   sbox_in = rs1_q[7:0];
            LANE1:   sbox_in = rs2_q[15:8];
            LANE2:   sbox_in = rs1_q[23:16];
            LANE3:   sbox_in = rs2_q[31:24];
            default: sbox_in = rs1_q[7:0];
        endcase
    end

    xc_aes_inv_sbox u_inv_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    // Staging word with the current lane replaced by the fresh substitution.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = (cnt_q == CNT_W'(gi)) ? sbox_out : work_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rot_d    = rot_q;
        work_d   = work_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        rs1_d   = rs1;
                        rs2_d   = rs2;
                        rot_d   = rot_sel ? rot : ROT_DEFAULT;
                        cnt_d   = '0;
                        state_d = SUB;
                    end
                end
                SUB: begin
                    if (!valid) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LANE3) begin
                        work_d  = rot_q ? rotl8(merged) : merged;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        work_d = merged;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Commit only on a completed handoff so aborted work never leaks out.
                    state_d = IDLE;
                    if (valid) begin
                        result_d = work_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rot_q    <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rot_q    <= rot_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == DONE) && valid && !flush;
    assign result = (state_q == DONE) ? work_q : result_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_xc_aessub_decrot_seq.sv
// Scoreboard bench for xc_aessub_decrot_seq: directed vectors push expected
// result and completion cycle; a negedge monitor checks every ready pulse.
module tb_xc_aessub_decrot_seq;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        valid   = 1'b0;
    logic        flush   = 1'b0;
    logic        rot_sel = 1'b0;
    logic        rot     = 1'b0;
    logic [31:0] rs1     = '0;
    logic [31:0] rs2     = '0;
    logic        ready;
    logic        busy;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n0;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    logic [31:0] mon_res;
    int          mon_cyc;

    xc_aessub_decrot_seq #(.ROT_DEFAULT(1'b1)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid   (valid),
        .flush   (flush),
        .rs1     (rs1),
        .rs2     (rs2),
        .rot_sel (rot_sel),
        .rot     (rot),
        .ready   (ready),
        .result  (result),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (ready) begin
            if (exp_res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready cycle=%0d actual=ready result=%h required=no ready", cyc, result);
            end else begin
                mon_res = exp_res_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                $display("txn cycle=%0d result=%h expected=%h expected_cycle=%0d", cyc, result, mon_res, mon_cyc);
                check("result", result, mon_res);
                check("ready_cycle", cyc, mon_cyc);
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sel,
                          input logic r, input logic [31:0] exp_v, input bit scramble);
        bit seen;
        seen = 1'b0;
        tick();
        rs1 = a; rs2 = b; rot_sel = sel; rot = r; valid = 1'b1;
        exp_res_q.push_back(exp_v);
        exp_cyc_q.push_back(cyc + 5);
        for (int i = 1; i <= 12 && !seen; i++) begin
            tick();
            if (scramble && i == 2) begin
                rs1 = ~a; rs2 = ~b; rot = ~r; rot_sel = ~sel;
            end
            if (ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=no ready required=ready within 12 cycles");
            exp_res_q.delete();
            exp_cyc_q.delete();
        end
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;

        run_op(32'h00630063, 32'h7C00FF00, 1'b1, 1'b0, 32'h01007D00, 1'b0);
        run_op(32'h00630063, 32'h7C00FF00, 1'b1, 1'b1, 32'h007D0001, 1'b0);
        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h52525252, 1'b0);
        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h52525252, 1'b0);
        run_op(32'h00630063, 32'h7C00FF00, 1'b0, 1'b0, 32'h007D0001, 1'b0);
        run_op(32'h00630063, 32'h7C00FF00, 1'b1, 1'b0, 32'h01007D00, 1'b1);

        // flush at N+3, restart at N+5
        tick();
        rs1 = 32'h00000000; rs2 = 32'h00000000; rot_sel = 1'b1; rot = 1'b0; valid = 1'b1;
        n0 = cyc;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        check("flush_busy", {31'b0, busy}, 32'h0);
        check("flush_result_held", result, 32'h01007D00);
        check("flush_cycle", cyc, n0 + 4);
        flush = 1'b0;
        valid = 1'b0;
        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h52525252, 1'b0);

        // valid dropped at N+2
        tick();
        rs1 = 32'h00630063; rs2 = 32'h7C00FF00; rot_sel = 1'b1; rot = 1'b0; valid = 1'b1;
        repeat (2) tick();
        valid = 1'b0;
        tick();
        check("vdrop_busy", {31'b0, busy}, 32'h0);
        check("vdrop_result_held", result, 32'h52525252);

        // valid and flush together in IDLE
        tick();
        valid = 1'b1;
        flush = 1'b1;
        tick();
        check("valid_flush_idle_busy", {31'b0, busy}, 32'h0);
        valid = 1'b0;
        flush = 1'b0;

        // reset at N+4 with valid still high
        tick();
        rs1 = 32'h00630063; rs2 = 32'h7C00FF00; rot_sel = 1'b1; rot = 1'b1; valid = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midreset_ready", {31'b0, ready}, 32'h0);
        check("midreset_result", result, 32'h0);
        check("midreset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        valid = 1'b0;

        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h52525252, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_res_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
